// File: rtl/grid_painter_if.sv
// Pixel-stream bundle between a grid source and the grid painter.
// The master drives the request and cell grid; the slave (painter) returns pixel writes.
interface grid_painter_if;
    logic        start;
    logic        hold;
    logic [39:0] dataIn [10];
    logic [10:0] x;
    logic [10:0] y;
    logic        pixel_color;
    logic        pixel_write;
    logic        busy;
    logic        done;

    modport master (
        output start,
        output hold,
        output dataIn,
        input  x,
        input  y,
        input  pixel_color,
        input  pixel_write,
        input  busy,
        input  done
    );

    modport slave (
        input  start,
        input  hold,
        input  dataIn,
        output x,
        output y,
        output pixel_color,
        output pixel_write,
        output busy,
        output done
    );
endinterface

// File: rtl/grid_painter.sv
// grid_painter: rasterises a 40x10 cell grid into one framebuffer pixel write per cycle.
// Optional macro GRID_PAINTER_GRIDLINES_EN blanks the first row and column of every cell.
module grid_painter #(
    parameter int unsigned CELL_SHIFT = 4,
    parameter int unsigned Y_BASE     = 0
) (
    input  logic          clock,
    input  logic          reset,
    grid_painter_if.slave bus
);
    localparam int unsigned GRID_COLS = 40;
    localparam int unsigned GRID_ROWS = 10;
    localparam logic [10:0] PX_LAST   = 11'((GRID_COLS << CELL_SHIFT) - 1);
    localparam logic [10:0] PY_LAST   = 11'((GRID_ROWS << CELL_SHIFT) - 1);
    localparam logic [10:0] CELL_MASK = 11'((1 << CELL_SHIFT) - 1);
    localparam logic [10:0] Y_OFFSET  = 11'(Y_BASE);

    typedef enum logic {
        IDLE  = 1'b0,
        PAINT = 1'b1
    } state_t;

    state_t      state_reg, state_next;
    logic [10:0] px_reg, px_next;
    logic [10:0] py_reg, py_next;
    logic        last_reg, last_next;
    logic [10:0] x_reg, x_next;
    logic [10:0] y_reg, y_next;
    logic        color_reg, color_next;
    logic        write_reg, write_next;
    logic        busy_reg, busy_next;
    logic        done_reg, done_next;
    logic        capture;

    logic [GRID_COLS-1:0] snapshot_reg [GRID_ROWS];

    logic [10:0]          cell_row;
    logic [10:0]          cell_col;
    logic [GRID_ROWS-1:0] row_hit;
    logic [GRID_COLS-1:0] col_hit;
    logic [GRID_COLS-1:0] row_bits;
    logic                 cell_value;
    logic                 on_gridline;
    logic                 cell_color;

    // Snapshot isolates the frame in progress from later dataIn changes.
    always_ff @(posedge clock) begin
        if (capture) begin
            for (int r = 0; r < GRID_ROWS; r++) begin
                snapshot_reg[r] <= bus.dataIn[r];
            end
        end
    end

    assign cell_row = py_reg >> CELL_SHIFT;
    assign cell_col = px_reg >> CELL_SHIFT;

    generate
        for (genvar gi = 0; gi < GRID_ROWS; gi++) begin : g_row_dec
            assign row_hit[gi] = (cell_row == 11'(gi));
        end
        for (genvar gi = 0; gi < GRID_COLS; gi++) begin : g_col_dec
            assign col_hit[gi] = (cell_col == 11'(gi));
        end
    endgenerate

    always_comb begin
        row_bits = '0;
        for (int r = 0; r < GRID_ROWS; r++) begin
            if (row_hit[r]) begin
                row_bits = row_bits | snapshot_reg[r];
            end
        end
    end

    assign cell_value = |(row_bits & col_hit);

`ifdef GRID_PAINTER_GRIDLINES_EN
    assign on_gridline = ((px_reg & CELL_MASK) == 11'd0) || ((py_reg & CELL_MASK) == 11'd0);
`else
    assign on_gridline = 1'b0;
`endif

    assign cell_color = cell_value & ~on_gridline;

    always_comb begin
        state_next = state_reg;
        px_next    = px_reg;
        py_next    = py_reg;
        last_next  = last_reg;
        x_next     = x_reg;
        y_next     = y_reg;
        color_next = color_reg;
        write_next = 1'b0;
        busy_next  = busy_reg;
        done_next  = 1'b0;
        capture    = 1'b0;

        case (state_reg)
            IDLE: begin
                busy_next = 1'b0;
                if (bus.start) begin
                    capture    = 1'b1;
                    px_next    = '0;
                    py_next    = '0;
                    last_next  = 1'b0;
                    busy_next  = 1'b1;
                    state_next = PAINT;
                end
            end
            PAINT: begin
                if (last_reg) begin
                    // Final pixel already presented: close the frame on this edge.
                    state_next = IDLE;
                    last_next  = 1'b0;
                    busy_next  = 1'b0;
                    done_next  = 1'b1;
                end else if (!bus.hold) begin
                    write_next = 1'b1;
                    x_next     = px_reg;
                    y_next     = py_reg + Y_OFFSET;
                    color_next = cell_color;
                    if (px_reg == PX_LAST) begin
                        px_next = '0;
                        if (py_reg == PY_LAST) begin
                            last_next = 1'b1;
                        end else begin
                            py_next = py_reg + 11'd1;
                        end
                    end else begin
                        px_next = px_reg + 11'd1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= IDLE;
            px_reg    <= '0;
            py_reg    <= '0;
            last_reg  <= 1'b0;
            x_reg     <= '0;
            y_reg     <= '0;
            color_reg <= 1'b0;
            write_reg <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            px_reg    <= px_next;
            py_reg    <= py_next;
            last_reg  <= last_next;
            x_reg     <= x_next;
            y_reg     <= y_next;
            color_reg <= color_next;
            write_reg <= write_next;
            busy_reg  <= busy_next;
            done_reg  <= done_next;
        end
    end

    assign bus.x           = x_reg;
    assign bus.y           = y_reg;
    assign bus.pixel_color = color_reg;
    assign bus.pixel_write = write_reg;
    assign bus.busy        = busy_reg;
    assign bus.done        = done_reg;
endmodule

// File: tb/tb_grid_painter.sv
// Randomised frame-level bench for grid_painter with a raster reference model.
// Uses CELL_SHIFT=1 (2x2-pixel cells, 1600 writes per frame) and Y_BASE=100.
module tb_grid_painter;
    localparam int CS   = 1;
    localparam int YB   = 100;
    localparam int CELL = 1 << CS;
    localparam int W    = 40 * CELL;
    localparam int H    = 10 * CELL;
    localparam int N    = W * H;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    grid_painter_if bus();

    grid_painter #(.CELL_SHIFT(CS), .Y_BASE(YB)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    bit [39:0] drv_grid   [10];
    bit [39:0] frame_grid [10];

    int lit_cnt, min_x, max_x, min_y, max_y;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic apply_grid();
        for (int r = 0; r < 10; r++) bus.dataIn[r] = drv_grid[r];
    endtask

    task automatic random_grid();
        logic [63:0] t;
        for (int r = 0; r < 10; r++) begin
            t = {$urandom(), $urandom()};
            drv_grid[r] = t[39:0];
        end
        apply_grid();
    endtask

    function automatic bit exp_color(input int px, input int py);
        bit c;
        c = frame_grid[py / CELL][px / CELL];
`ifdef GRID_PAINTER_GRIDLINES_EN
        if ((px % CELL) == 0 || (py % CELL) == 0) c = 1'b0;
`endif
        return c;
    endfunction

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic begin_frame(input bit keep_start);
        frame_grid = drv_grid;
        bus.start = 1'b1;
        tick();
        if (!keep_start) bus.start = 1'b0;
        check("busy_rise", 64'(bus.busy), 64'd1);
    endtask

    // Called on the first negedge after start is accepted; follows the frame to completion.
    task automatic paint_body(input int hold_mode, input int poke_at, input int abort_at,
                              input bit keep_start);
        int k = 0;
        int c = 1;
        int holds = 0;
        int dones = 0;
        bit hold_last;
        logic [22:0] exp_pix;
        lit_cnt = 0; min_x = 9999; max_x = -1; min_y = 9999; max_y = -1;
        check("first_gap", 64'(bus.pixel_write), 64'd0);
        while (k < N && c < 4 * N) begin
            hold_last = (hold_mode != 0) && ($urandom_range(0, 2) == 0);
            bus.hold = hold_last;
            tick();
            c++;
            if (bus.done) dones++;
            if (hold_last) begin
                holds++;
                check("hold_gap", 64'(bus.pixel_write), 64'd0);
            end else begin
                check("write", 64'(bus.pixel_write), 64'd1);
                if (bus.pixel_write) begin
                    exp_pix = {11'(k % W), 11'(k / W + YB), exp_color(k % W, k / W)};
                    check("pixel", 64'({bus.x, bus.y, bus.pixel_color}), 64'(exp_pix));
                    check("busy", 64'(bus.busy), 64'd1);
                    if (bus.pixel_color) begin
                        lit_cnt++;
                        if (int'(bus.x) < min_x) min_x = int'(bus.x);
                        if (int'(bus.x) > max_x) max_x = int'(bus.x);
                        if (int'(bus.y) < min_y) min_y = int'(bus.y);
                        if (int'(bus.y) > max_y) max_y = int'(bus.y);
                    end
                    k++;
                    if (k == poke_at) begin
                        random_grid();
                        bus.start = 1'b1;
                    end else if (!keep_start) begin
                        bus.start = 1'b0;
                    end
                    if (k == abort_at) begin
                        bus.hold = 1'b0;
                        reset = 1'b1;
                        tick();
                        reset = 1'b0;
                        check("rst_out", 64'({bus.x, bus.y, bus.pixel_color, bus.pixel_write,
                                               bus.busy, bus.done}), 64'd0);
                        dones = 0;
                        for (int i = 0; i < 4; i++) begin
                            tick();
                            if (bus.done || bus.busy || bus.pixel_write) dones++;
                        end
                        check("rst_quiet", 64'(dones), 64'd0);
                        return;
                    end
                end
            end
        end
        bus.hold = 1'b0;
        check("write_count", 64'(k), 64'(N));
        check("frame_len", 64'(c), 64'(1 + N + holds));
        check("no_early_done", 64'(dones), 64'd0);
        tick();
        check("done_pulse", 64'({bus.done, bus.busy, bus.pixel_write}), 64'b100);
        if (!keep_start) begin
            tick();
            check("done_clear", 64'({bus.done, bus.busy}), 64'd0);
        end
        $display("frame: writes=%0d holds=%0d cycles=%0d lit=%0d", k, holds, c, lit_cnt);
    endtask

    initial begin
        int lo_x, hi_x, lo_y, hi_y;
        reset = 1'b1;
        bus.start = 1'b0;
        bus.hold = 1'b0;
        for (int r = 0; r < 10; r++) drv_grid[r] = '0;
        apply_grid();
        repeat (3) tick();
        check("rst_x", 64'(bus.x), 64'd0);
        check("rst_y", 64'(bus.y), 64'd0);
        check("rst_color", 64'(bus.pixel_color), 64'd0);
        check("rst_write", 64'(bus.pixel_write), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        reset = 1'b0;
        tick();

        // All cells lit: full raster with every pixel lit (except gridlines when enabled).
        for (int r = 0; r < 10; r++) drv_grid[r] = '1;
        apply_grid();
        begin_frame(1'b0);
        paint_body(0, -1, -1, 1'b0);

        // Single lit cell at row 2, column 5.
        for (int r = 0; r < 10; r++) drv_grid[r] = '0;
        drv_grid[2][5] = 1'b1;
        apply_grid();
        begin_frame(1'b0);
        paint_body(0, -1, -1, 1'b0);
        lo_x = 5 * CELL; hi_x = 6 * CELL - 1;
        lo_y = YB + 2 * CELL; hi_y = YB + 3 * CELL - 1;
`ifdef GRID_PAINTER_GRIDLINES_EN
        lo_x++; lo_y++;
`endif
        check("cell_lit_cnt", 64'(lit_cnt), 64'((hi_x - lo_x + 1) * (hi_y - lo_y + 1)));
        check("cell_min_x", 64'(min_x), 64'(lo_x));
        check("cell_max_x", 64'(max_x), 64'(hi_x));
        check("cell_min_y", 64'(min_y), 64'(lo_y));
        check("cell_max_y", 64'(max_y), 64'(hi_y));

        // Random grid with hold asserted about one cycle in three.
        random_grid();
        begin_frame(1'b0);
        paint_body(1, -1, -1, 1'b0);

        // dataIn changed and start re-pulsed mid-frame: must not restart or re-capture.
        random_grid();
        begin_frame(1'b0);
        paint_body(0, N / 3, -1, 1'b0);
        bus.start = 1'b0;
        repeat (3) tick();
        check("no_requeue", 64'(bus.busy), 64'd0);

        // Reset at write 500, then a complete frame from (0,0).
        random_grid();
        begin_frame(1'b0);
        paint_body(0, -1, 500, 1'b0);
        random_grid();
        begin_frame(1'b0);
        paint_body(1, -1, -1, 1'b0);

        // start held high: second frame follows done with a fresh snapshot.
        random_grid();
        begin_frame(1'b1);
        paint_body(0, N / 2, -1, 1'b1);
        frame_grid = drv_grid;
        tick();
        bus.start = 1'b0;
        check("rerun_busy", 64'(bus.busy), 64'd1);
        paint_body(0, -1, -1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
